// File: rtl/pu_controller.sv
// pu_controller: sequencing FSM for one neuron processing unit.
// For each of NUM_NEURONS neurons it fetches the input/weight/bias vector,
// clears the accumulator, runs NUM_ROUNDS multiply-accumulate rounds,
// captures the activation and writes it to the result buffer.
module pu_controller #(
    parameter int NUM_ROUNDS  = 8,
    parameter int NUM_NEURONS = 30,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             data_req,
    input  logic             data_ack,
    output logic [IDX_W-1:0] neuron_idx,
    output logic             read_data_reg_ld,
    output logic             acc_rst,
    output logic             ld,
    output logic [3:0]       round,
    output logic             mult_done,
    input  logic [7:0]       pu_out,
    output logic             out_we,
    output logic [IDX_W-1:0] out_addr,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CLEAR   = 3'd2,
        S_ACCUM   = 3'd3,
        S_CAPTURE = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [3:0]       LAST_ROUND  = 4'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] LAST_NEURON = IDX_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

    state_t state;

    // NOTE: the load strobe must be seen by the datapath in the very cycle the
    // vector is on the bus, so it is decoded from data_ack rather than registered.
    assign read_data_reg_ld = (state == S_REQ) && data_ack;

    // The result buffer is addressed by the neuron currently being processed.
    assign out_addr = neuron_idx;

    // State register plus registered outputs: every transition sets the output
    // values that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= S_IDLE;
            neuron_idx <= '0;
            round      <= '0;
            out_data   <= '0;
            data_req   <= 1'b0;
            acc_rst    <= 1'b0;
            ld         <= 1'b0;
            mult_done  <= 1'b0;
            out_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Single-cycle strobes default low; states raise them as needed.
            acc_rst   <= 1'b0;
            mult_done <= 1'b0;
            out_we    <= 1'b0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_REQ;
                        neuron_idx <= '0;
                        data_req   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_REQ: begin
                    // Wait for upstream memory; the vector is latched in the ack cycle.
                    if (data_ack) begin
                        state    <= S_CLEAR;
                        data_req <= 1'b0;
                        acc_rst  <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    state     <= S_ACCUM;
                    round     <= '0;
                    ld        <= 1'b1;
                    mult_done <= (LAST_ROUND == 4'd0);
                end

                S_ACCUM: begin
                    if (round == LAST_ROUND) begin
                        state <= S_CAPTURE;
                        ld    <= 1'b0;
                        round <= '0;
                    end else begin
                        round     <= round + 4'd1;
                        mult_done <= ((round + 4'd1) == LAST_ROUND);
                    end
                end

                S_CAPTURE: begin
                    // Activation is valid now; freeze it for the write cycle.
                    state    <= S_WRITE;
                    out_data <= pu_out;
                    out_we   <= 1'b1;
                end

                S_WRITE: begin
                    if (neuron_idx == LAST_NEURON) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= S_REQ;
                        neuron_idx <= neuron_idx + IDX_ONE;
                        data_req   <= 1'b1;
                    end
                end

                S_DONE: begin
                    state      <= S_IDLE;
                    neuron_idx <= '0;
                    busy       <= 1'b0;
                end

                default: begin
                    // Unused encoding: fall back to a quiet IDLE.
                    state      <= S_IDLE;
                    neuron_idx <= '0;
                    round      <= '0;
                    data_req   <= 1'b0;
                    ld         <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_controller.sv
// tb_pu_controller: scoreboard bench for pu_controller (4 neurons, 8 rounds).
// Stimulus pushes the expected event stream; a negedge monitor pops and
// compares every acc_rst, mult_done, out_we and done it observes.
module tb_pu_controller;

    localparam int NR = 8;
    localparam int NN = 4;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst, start, data_ack;
    logic          data_req, read_data_reg_ld, acc_rst, ld, mult_done;
    logic          out_we, busy, done;
    logic [IW-1:0] neuron_idx, out_addr;
    logic [3:0]    round;
    logic [7:0]    pu_out, out_data, pu_base;

    pu_controller #(.NUM_ROUNDS(NR), .NUM_NEURONS(NN), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .data_req(data_req), .data_ack(data_ack), .neuron_idx(neuron_idx),
        .read_data_reg_ld(read_data_reg_ld), .acc_rst(acc_rst), .ld(ld),
        .round(round), .mult_done(mult_done), .pu_out(pu_out),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: activation depends on the neuron; during the write
    // cycle it shows junk so a transparent out_data would be exposed.
    assign pu_out = out_we ? 8'hFF : (pu_base ^ {3'b000, neuron_idx});

    typedef enum {EV_ACC, EV_MD, EV_WR, EV_DONE} ev_e;
    typedef struct {
        ev_e        kind;
        int         val;
        logic [7:0] data;
    } ev_t;

    ev_t        sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         t0    = 0;
    bit         mon_en = 0;
    int         ldcnt = 0;
    bit         hold_pend = 0;
    logic [7:0] hold_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_e k, input int v, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic got(input ev_e k, input int v, input logic [7:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            check($sformatf("unexpected_%s", k.name()), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check($sformatf("%s_value", e.kind.name()), v, e.val);
            if (k == EV_WR) check("write_data", {24'd0, d}, {24'd0, e.data});
        end
    endtask

    // Monitor: invariants every cycle plus scoreboard pops on output events.
    always @(negedge clk) begin
        int rel;
        if (mon_en) begin
            rel = cyc - t0 + 1;
            check("round_range", 32'(round < 4'(NR)), 32'd1);
            check("strobe_onehot", 32'($onehot0({ld, acc_rst, data_req, out_we, done})), 32'd1);
            if (mult_done) begin
                check("md_implies_ld", {31'd0, ld}, 32'd1);
                check("md_round", {28'd0, round}, 32'(NR - 1));
            end
            if (out_we) check("out_addr_range", 32'(out_addr < IW'(NN)), 32'd1);
            if (read_data_reg_ld) check("rdl_only_in_req", {31'd0, data_req}, 32'd1);
            if (!ld) check("round_zero_outside_accum", {28'd0, round}, 32'd0);
            if (hold_pend) begin
                check("out_data_hold", {24'd0, out_data}, {24'd0, hold_val});
                hold_pend = 0;
            end
            if (ld) ldcnt++;
            if (acc_rst) begin
                ldcnt = 0;
                got(EV_ACC, rel, 8'h00);
            end
            if (mult_done) got(EV_MD, ldcnt, 8'h00);
            if (out_we) begin
                got(EV_WR, int'(out_addr), out_data);
                hold_pend = 1;
                hold_val  = out_data;
            end
            if (done) got(EV_DONE, rel, 8'h00);
        end
    end

    // Expected stream for a full run: acc_rst, mult_done (8 ld cycles), write.
    task automatic push_run(input int first_acc, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3, input int done_rel);
        logic [7:0] dv[4];
        dv = '{d0, d1, d2, d3};
        for (int n = 0; n < NN; n++) begin
            push(EV_ACC, first_acc + 12 * n, 8'h00);
            push(EV_MD, NR, 8'h00);
            push(EV_WR, n, dv[n]);
        end
        push(EV_DONE, done_rel, 8'h00);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_round"}, {28'd0, round}, 32'd0);
        check({tag, "_idx"}, {27'd0, neuron_idx}, 32'd0);
        check({tag, "_strobes"}, {26'd0, data_req, ld, acc_rst, out_we, done, mult_done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout expected completion)");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; data_ack = 1'b0; pu_base = 8'h00;
        repeat (3) @(negedge clk);
        // start while reset is held must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_quiet("reset");
        check("reset_out_data", {24'd0, out_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");
        mon_en = 1;

        // Run A: immediate ack, start pulsed in ACCUM and in DONE
        data_ack = 1'b1; pu_base = 8'h5A;
        push_run(2, 8'h5A, 8'h5B, 8'h58, 8'h59, 49);
        do_start();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ld) begin found = 1; break; end
        end
        check("ld_timeout", {31'd0, found}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_quiet("after_done");
        repeat (5) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Run B: ack withheld for five REQ cycles
        data_ack = 1'b0; pu_base = 8'h33;
        push_run(7, 8'h33, 8'h32, 8'h31, 8'h30, 54);
        do_start();
        for (int i = 0; i < 5; i++) begin
            check("wait_data_req", {31'd0, data_req}, 32'd1);
            check("wait_no_ld", {29'd0, ld, acc_rst, read_data_reg_ld}, 32'd0);
            @(negedge clk);
        end
        data_ack = 1'b1;
        #1;
        check("ack_rdl", {31'd0, read_data_reg_ld}, 32'd1);
        check("ack_data_req", {31'd0, data_req}, 32'd1);
        wait_done(100);
        @(negedge clk);
        check("rdl_in_idle", {31'd0, read_data_reg_ld}, 32'd0);

        // Run C: reset at round 4 of neuron 3
        pu_base = 8'h5A;
        for (int n = 0; n < 3; n++) begin
            push(EV_ACC, 2 + 12 * n, 8'h00);
            push(EV_MD, NR, 8'h00);
        end
        sb.delete();
        for (int n = 0; n < 3; n++) begin
            push(EV_ACC, 2 + 12 * n, 8'h00);
            push(EV_MD, NR, 8'h00);
            push(EV_WR, n, (n == 0) ? 8'h5A : (n == 1) ? 8'h5B : 8'h58);
        end
        push(EV_ACC, 38, 8'h00);
        do_start();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ld && neuron_idx == 5'd3 && round == 4'd4) begin found = 1; break; end
        end
        check("mid_neuron_timeout", {31'd0, found}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("mid_reset");
        check("mid_reset_out_data", {24'd0, out_data}, 32'd0);
        repeat (6) @(negedge clk);
        check("post_mid_reset_busy", {31'd0, busy}, 32'd0);

        // Run D: fresh start after reset restarts at neuron 0
        pu_base = 8'hC3;
        push_run(2, 8'hC3, 8'hC2, 8'hC1, 8'hC0, 49);
        do_start();
        check("restart_idx", {27'd0, neuron_idx}, 32'd0);
        wait_done(100);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
